cadence_meas: RTL and testbench

- Conditions the raw pedal-cadence pulse and measures its period for the e-bike sensor-conditioning path.
- Sits directly downstream of the bench cadence stimulus, i.e. the cadence line driven by the test tasks, and upstream of the torque/assist math.
- Outputs a filtered cadence level, a rise pulse, a quantised period and a not_pedaling flag.

---
 rtl/ebike_pkg.sv | 13 +
 rtl/cadence_filt.sv | 48 ++++
 rtl/cadence_meas.sv | 70 +++++++
 tb/tb_cadence_meas.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ebike_pkg.sv
// rtl/ebike_pkg.sv - shared constants and types for the e-bike sensor-conditioning path
package ebike_pkg;

  localparam int FILT_CNT_FAST = 16;
  localparam int FILT_CNT_SLOW = 1024;
  localparam int PRE_W_FAST    = 4;
  localparam int PRE_W_SLOW    = 16;

  typedef logic [7:0] cad_per_t;

  localparam cad_per_t CAD_PER_SAT = 8'hFF;

endpackage

// File: rtl/cadence_filt.sv
// rtl/cadence_filt.sv - cadence synchroniser, glitch filter and rising-edge detect
module cadence_filt
  import ebike_pkg::*;
#(
  parameter int FILT_CNT = FILT_CNT_FAST
) (
  input  logic clk,
  input  logic rst,
  input  logic cadence,
  output logic filt,
  output logic rise
);

  localparam int            FW   = $clog2(FILT_CNT);
  localparam logic [FW-1:0] FMAX = FW'(FILT_CNT - 1);

  logic [2:0]    sync;
  logic [FW-1:0] fcnt;
  logic          filt_q;
  logic          s;

  assign s = sync[2];

  // Comparing against the stage feeding s clears fcnt on the same edge s changes,
  // so a one-cycle change of s can never meet a saturated counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync   <= '0;
      fcnt   <= '0;
      filt   <= 1'b0;
      filt_q <= 1'b0;
    end else begin
      sync <= {sync[1:0], cadence};
      if (sync[1] != s) begin
        fcnt <= '0;
      end else if (fcnt != FMAX) begin
        fcnt <= fcnt + FW'(1);
      end
      if (fcnt == FMAX && s != filt) begin
        filt <= s;
      end
      filt_q <= filt;
    end
  end

  assign rise = filt & ~filt_q;

endmodule

// File: rtl/cadence_meas.sv
// rtl/cadence_meas.sv - pedal cadence conditioning, period measurement and stall detection
module cadence_meas
  import ebike_pkg::*;
#(
  parameter bit FAST_SIM = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cadence,
  output logic       cadence_filt,
  output logic       cadence_rise,
  output logic [7:0] cadence_per,
  output logic       cadence_vld,
  output logic       not_pedaling
);

  localparam int       FILT_CNT = FAST_SIM ? FILT_CNT_FAST : FILT_CNT_SLOW;
  localparam int       PRE_W    = FAST_SIM ? PRE_W_FAST : PRE_W_SLOW;
  localparam cad_per_t CNT_LAST = CAD_PER_SAT - 8'd1;

  logic [PRE_W-1:0] pre;
  cad_per_t         cnt;
  logic             tick;

  cadence_filt #(
    .FILT_CNT(FILT_CNT)
  ) u_filt (
    .clk    (clk),
    .rst    (rst),
    .cadence(cadence),
    .filt   (cadence_filt),
    .rise   (cadence_rise)
  );

  assign tick = &pre;

  // A rise restarts timing and takes priority over a coincident tick, including the stall tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre          <= '0;
      cnt          <= '0;
      cadence_per  <= CAD_PER_SAT;
      cadence_vld  <= 1'b0;
      not_pedaling <= 1'b1;
    end else begin
      cadence_vld <= 1'b0;
      if (cadence_rise) begin
        pre <= '0;
        cnt <= '0;
        if (not_pedaling) begin
          not_pedaling <= 1'b0;
        end else begin
          cadence_per <= cnt;
          cadence_vld <= 1'b1;
        end
      end else begin
        pre <= pre + PRE_W'(1);
        if (tick && cnt != CAD_PER_SAT) begin
          cnt <= cnt + 8'd1;
          if (cnt == CNT_LAST && !not_pedaling) begin
            not_pedaling <= 1'b1;
            cadence_per  <= CAD_PER_SAT;
            cadence_vld  <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cadence_meas.sv
// tb/tb_cadence_meas.sv - self-checking bench for cadence_meas with a behavioural period model
module tb_cadence_meas;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cadence = 1'b0;
  logic       cadence_filt;
  logic       cadence_rise;
  logic [7:0] cadence_per;
  logic       cadence_vld;
  logic       not_pedaling;

  int n_chk = 0;
  int n_pass = 0;

  cadence_meas #(
    .FAST_SIM(1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cadence     (cadence),
    .cadence_filt(cadence_filt),
    .cadence_rise(cadence_rise),
    .cadence_per (cadence_per),
    .cadence_vld (cadence_vld),
    .not_pedaling(not_pedaling)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Model: edges since reset, edge of the last rise capture, raw sample history.
  int          m_e;
  int          m_base;
  logic [18:0] m_hist;
  logic        m_filt, m_rise, m_vld, m_np;
  logic [7:0]  m_per;

  initial begin
    logic [15:0] win;
    logic        prev;
    int          ticks;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_e = 0; m_base = 0; m_hist = '0;
        m_filt = 1'b0; m_rise = 1'b0; m_vld = 1'b0; m_np = 1'b1; m_per = 8'hFF;
      end else begin
        m_e++;
        m_hist = {m_hist[17:0], cadence};
        m_vld = 1'b0;
        if (m_rise) begin
          ticks = (m_e - m_base - 1) / 16;
          if (ticks > 255) ticks = 255;
          if (m_np) m_np = 1'b0;
          else begin
            m_per = 8'(ticks);
            m_vld = 1'b1;
          end
          m_base = m_e;
        end else if (!m_np && (m_e - m_base) == 16 * 255) begin
          m_np = 1'b1; m_per = 8'hFF; m_vld = 1'b1;
        end
        // filtered level follows only 16 identical samples seen through the 3-flop delay
        win  = m_hist[18:3];
        prev = m_filt;
        if (win == 16'h0000) m_filt = 1'b0;
        else if (win == 16'hFFFF) m_filt = 1'b1;
        m_rise = m_filt & ~prev;
      end
    end
  end

  int         vld_cnt = 0;
  int         rise_cnt = 0;
  logic [7:0] last_per = 8'h00;

  initial begin
    logic [11:0] act, exp;
    forever begin
      @(negedge clk);
      act = {cadence_filt, cadence_rise, cadence_vld, not_pedaling, cadence_per};
      if (rst) exp = {1'b0, 1'b0, 1'b0, 1'b1, 8'hFF};
      else exp = {m_filt, m_rise, m_vld, m_np, m_per};
      check("cycle", 32'(act), 32'(exp));
      if (cadence_vld) begin
        vld_cnt++;
        last_per = cadence_per;
      end
      if (cadence_rise) rise_cnt++;
    end
  end

  task automatic step(input logic c);
    @(negedge clk);
    #1;
    cadence = c;
  endtask

  task automatic hold(input logic c, input int n);
    repeat (n) step(c);
  endtask

  task automatic wave(input int per, input int hi, input int reps);
    repeat (reps) begin
      hold(1'b1, hi);
      hold(1'b0, per - hi);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    #1;
    rst = 1'b1;
    repeat (n) @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int v0, r0, guard, hi, lo, g;

    // 1: reset with cadence high, then exact filter latency
    rst = 1'b1;
    cadence = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
    check("t1_per_reset", 32'(cadence_per), 32'h0FF);
    check("t1_np_reset", 32'(not_pedaling), 32'h1);
    check("t1_filt_reset", 32'(cadence_filt), 32'h0);
    hold(1'b1, 18);
    check("t1_filt_at18", 32'(cadence_filt), 32'h0);
    step(1'b1);
    check("t1_filt_at19", 32'(cadence_filt), 32'h1);
    check("t1_rise_at19", 32'(cadence_rise), 32'h1);

    // 2: short pulses rejected, a 16-clock pulse accepted
    cadence = 1'b0;
    do_reset(3);
    hold(1'b0, 30);
    r0 = rise_cnt; v0 = vld_cnt;
    hold(1'b1, 10); hold(1'b0, 40);
    check("t2_pulse10_rise", 32'(rise_cnt - r0), 32'h0);
    check("t2_pulse10_vld", 32'(vld_cnt - v0), 32'h0);
    hold(1'b1, 15); hold(1'b0, 40);
    check("t2_pulse15_rise", 32'(rise_cnt - r0), 32'h0);
    hold(1'b1, 16); hold(1'b0, 40);
    check("t2_pulse16_rise", 32'(rise_cnt - r0), 32'h1);

    // 3: 640-clock wave from a fresh reset
    do_reset(2);
    hold(1'b0, 40);
    v0 = vld_cnt;
    wave(640, 320, 1);
    check("t3_np_cleared", 32'(not_pedaling), 32'h0);
    check("t3_first_no_vld", 32'(vld_cnt - v0), 32'h0);
    wave(640, 320, 3);
    check("t3_vld_count", 32'(vld_cnt - v0), 32'h3);
    check("t3_per", 32'(last_per), 32'h27);

    // 4: stall, then recovery
    v0 = vld_cnt;
    hold(1'b0, 4200);
    check("t4_stall_vld", 32'(vld_cnt - v0), 32'h1);
    check("t4_stall_per", 32'(last_per), 32'hFF);
    check("t4_stall_np", 32'(not_pedaling), 32'h1);
    v0 = vld_cnt;
    wave(640, 320, 2);
    check("t4_recover_vld", 32'(vld_cnt - v0), 32'h1);
    check("t4_recover_per", 32'(last_per), 32'h27);

    // 5: period changes
    wave(160, 80, 4);
    check("t5_per160", 32'(last_per), 32'h09);
    wave(320, 160, 3);
    check("t5_per320", 32'(last_per), 32'h13);

    // rise landing on the tick that would declare the stall
    v0 = vld_cnt;
    guard = 0;
    while (m_e < m_base + 4060 && guard < 6000) begin
      step(1'b0);
      guard++;
    end
    check("bnd_reached", 32'(m_e - m_base), 32'd4060);
    cadence = 1'b1;
    hold(1'b1, 40);
    check("bnd_vld", 32'(vld_cnt - v0), 32'h1);
    check("bnd_per", 32'(last_per), 32'hFE);
    check("bnd_np", 32'(not_pedaling), 32'h0);
    hold(1'b1, 280); hold(1'b0, 320);

    // 6: reset in the middle of a 640 wave
    wave(640, 320, 1);
    hold(1'b1, 200);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("t6_reset_immediate",
          32'({cadence_filt, cadence_rise, cadence_vld, not_pedaling, cadence_per}),
          32'({1'b0, 1'b0, 1'b0, 1'b1, 8'hFF}));
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    hold(1'b0, 320);
    v0 = vld_cnt;
    wave(640, 320, 2);
    check("t6_vld_count", 32'(vld_cnt - v0), 32'h1);
    check("t6_per", 32'(last_per), 32'h27);

    // randomized waves with glitches and occasional resets, checked by the model every cycle
    for (int i = 0; i < 25; i++) begin
      hi = int'($urandom_range(20, 300));
      lo = int'($urandom_range(20, 300));
      if ($urandom_range(0, 3) == 0) begin
        g = int'($urandom_range(1, 15));
        hold(1'b1, hi / 2); hold(1'b0, g); hold(1'b1, hi - hi / 2);
      end else begin
        hold(1'b1, hi);
      end
      if ($urandom_range(0, 3) == 0) begin
        g = int'($urandom_range(1, 15));
        hold(1'b0, lo / 2); hold(1'b1, g); hold(1'b0, lo - lo / 2);
      end else begin
        hold(1'b0, lo);
      end
      if ($urandom_range(0, 9) == 0) do_reset(int'($urandom_range(1, 4)));
    end
    hold(1'b0, 50);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
